// File: rtl/alu_operand_pairer_pkg.sv
// -----------------------------------------------------------------------------
// alu_pair_pkg
// Shared types for the ALU operand pairer: FSM state encoding and the
// INP_VALID patterns (bit 0 = OPA present, bit 1 = OPB present).
// -----------------------------------------------------------------------------
package alu_pair_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT_A = 2'b01,
    WAIT_B = 2'b10,
    HOLD   = 2'b11
  } pair_state_t;

  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

endpackage

// File: rtl/alu_operand_pairer_if.sv
// -----------------------------------------------------------------------------
// alu_operand_pairer_if
// Stimulus-side operand bus plus the paired-operation output handshake.
//   CE, INP_VALID, MODE, CMD, CIN, OPA, OPB : operand inputs to the pairer
//   in_ready                                 : pairer accepts inputs this cycle
//   out_valid/out_ready                      : paired-operation handshake
//   out_mode/out_cmd/out_cin/out_opa/out_opb : paired fields
//   ERR                                      : operation was formed by a timeout
// Modports: master = stimulus/ALU-core side, slave = the pairer.
// -----------------------------------------------------------------------------
interface alu_operand_pairer_if #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4
);
  logic                 CE;
  logic [1:0]           INP_VALID;
  logic                 MODE;
  logic [CMD_WIDTH-1:0] CMD;
  logic                 CIN;
  logic [OP_WIDTH-1:0]  OPA;
  logic [OP_WIDTH-1:0]  OPB;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_mode;
  logic [CMD_WIDTH-1:0] out_cmd;
  logic                 out_cin;
  logic [OP_WIDTH-1:0]  out_opa;
  logic [OP_WIDTH-1:0]  out_opb;
  logic                 ERR;

  modport master (
    output CE, INP_VALID, MODE, CMD, CIN, OPA, OPB, out_ready,
    input  in_ready, out_valid, out_mode, out_cmd, out_cin, out_opa, out_opb, ERR
  );

  modport slave (
    input  CE, INP_VALID, MODE, CMD, CIN, OPA, OPB, out_ready,
    output in_ready, out_valid, out_mode, out_cmd, out_cin, out_opa, out_opb, ERR
  );
endinterface

// File: rtl/alu_operand_pairer_timer.sv
// -----------------------------------------------------------------------------
// alu_pair_timer
// Wait-window counter for the missing operand.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the window (count to 0), has priority over inc
//   inc      : advance the count by one
//   expired  : count has reached TIMEOUT-1 (last cycle of the window)
// -----------------------------------------------------------------------------
module alu_pair_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int              CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The owner never asserts inc once expired, so the count cannot wrap.
  always_comb begin
    count_d = count_q;
    if (clear)    count_d = '0;
    else if (inc) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = (count_q == LAST);
endmodule

// File: rtl/alu_operand_pairer.sv
// -----------------------------------------------------------------------------
// alu_operand_pairer
// ALU front end: pairs OPA and OPB arriving on the same or different cycles,
// bounds the wait for the second operand to TIMEOUT CE-qualified cycles, and
// presents one registered operation over a valid/ready handshake.
// Ports:
//   CLK, RST      : clock, synchronous active-high reset (RST wins over all)
//   bus (slave)   : operand inputs, in_ready, output handshake and fields
//   timeout_count : (ALU_PAIR_TIMEOUT_CNT_EN only) saturating count of
//                   transfers that carried ERR=1
// Optional feature macro: ALU_PAIR_TIMEOUT_CNT_EN.
// -----------------------------------------------------------------------------
import alu_pair_pkg::*;

module alu_operand_pairer #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic CLK,
  input  logic RST,
  alu_operand_pairer_if.slave bus
`ifdef ALU_PAIR_TIMEOUT_CNT_EN
  ,
  output logic [15:0] timeout_count
`endif
);
  pair_state_t          state_q, state_d;
  logic [OP_WIDTH-1:0]  opa_q, opb_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 mode_q, cin_q, err_q;

  logic fresh, fresh_acc, wait_a_ce, wait_b_ce;
  logic cap_a, cap_b, cap_ctl, zero_a, zero_b;
  logic tmr_clr, tmr_inc, expired;

  alu_pair_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .clear  (tmr_clr),
    .inc    (tmr_inc),
    .expired(expired)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. IDLE and a completing HOLD behave identically: both
  // route a newly accepted input straight to its destination.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: begin
        if (state_q == HOLD && !bus.out_ready) begin
          state_d = HOLD;
        end else if (bus.CE) begin
          case (bus.INP_VALID)
            IV_AB:   state_d = HOLD;
            IV_A:    state_d = WAIT_B;
            IV_B:    state_d = WAIT_A;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_B:  if (bus.CE && (bus.INP_VALID[1] || expired)) state_d = HOLD;
      WAIT_A:  if (bus.CE && (bus.INP_VALID[0] || expired)) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath-control logic
  always_comb begin
    fresh     = (state_q == IDLE) || (state_q == HOLD && bus.out_ready);
    fresh_acc = fresh && bus.CE;
    wait_a_ce = (state_q == WAIT_A) && bus.CE;
    wait_b_ce = (state_q == WAIT_B) && bus.CE;

    cap_a   = (fresh_acc || wait_a_ce) && bus.INP_VALID[0];
    cap_b   = (fresh_acc || wait_b_ce) && bus.INP_VALID[1];
    // Control fields come only with the first capture; later ones are ignored.
    cap_ctl = fresh_acc && (bus.INP_VALID != IV_NONE);
    zero_a  = wait_a_ce && !bus.INP_VALID[0] && expired;
    zero_b  = wait_b_ce && !bus.INP_VALID[1] && expired;

    tmr_clr = fresh_acc;
    // A repeated first operand is not a completion and does not restart the window.
    tmr_inc = (wait_a_ce && !bus.INP_VALID[0] && !expired) ||
              (wait_b_ce && !bus.INP_VALID[1] && !expired);

    bus.in_ready  = (state_q != HOLD) || bus.out_ready;
    bus.out_valid = (state_q == HOLD);
  end

  // Captured operation fields; untouched while HOLD waits on out_ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      opa_q  <= '0;
      opb_q  <= '0;
      cmd_q  <= '0;
      mode_q <= 1'b0;
      cin_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (cap_a)       opa_q <= bus.OPA;
      else if (zero_a) opa_q <= '0;
      if (cap_b)       opb_q <= bus.OPB;
      else if (zero_b) opb_q <= '0;
      if (cap_ctl) begin
        mode_q <= bus.MODE;
        cmd_q  <= bus.CMD;
        cin_q  <= bus.CIN;
      end
      if (cap_a || cap_b || zero_a || zero_b) err_q <= zero_a || zero_b;
    end
  end

  assign bus.out_opa  = opa_q;
  assign bus.out_opb  = opb_q;
  assign bus.out_cmd  = cmd_q;
  assign bus.out_mode = mode_q;
  assign bus.out_cin  = cin_q;
  assign bus.ERR      = err_q && (state_q == HOLD);

`ifdef ALU_PAIR_TIMEOUT_CNT_EN
  logic [15:0] tcnt_q;
  logic        err_xfer;

  assign err_xfer = (state_q == HOLD) && bus.out_ready && err_q;

  always_ff @(posedge CLK) begin
    if (RST)                              tcnt_q <= '0;
    else if (err_xfer && tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
  end

  assign timeout_count = tcnt_q;
`endif
endmodule

// File: tb/tb_alu_operand_pairer.sv
module tb_alu_operand_pairer;
  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  alu_operand_pairer_if #(.OP_WIDTH(8), .CMD_WIDTH(4)) bus ();

`ifdef ALU_PAIR_TIMEOUT_CNT_EN
  logic [15:0] timeout_count;
`endif

  alu_operand_pairer #(.OP_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef ALU_PAIR_TIMEOUT_CNT_EN
    ,
    .timeout_count(timeout_count)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] cmd);
    bus.INP_VALID = iv;
    bus.OPA       = a;
    bus.OPB       = b;
    bus.CMD       = cmd;
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic err);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_opa"},   32'(bus.out_opa),   32'(a));
    check({tag, "_opb"},   32'(bus.out_opb),   32'(b));
    check({tag, "_err"},   32'(bus.ERR),       32'(err));
  endtask

  // OPB alone, then 16 CE cycles of silence: operation emerges with ERR=1, OPA zeroed.
  task automatic run_timeout();
    drive(2'b10, 8'h77, 8'h0F, 4'd2);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    step(15);
    check("s3_not_yet", 32'(bus.out_valid), 0);
    step();
    check_op("s3", 8'h00, 8'h0F, 1'b1);
    step();
    check("s3_done_valid", 32'(bus.out_valid), 0);
    check("s3_done_err",   32'(bus.ERR),       0);
  endtask

  initial begin
    RST           = 1'b1;
    bus.CE        = 1'b1;
    bus.MODE      = 1'b0;
    bus.CIN       = 1'b0;
    bus.out_ready = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    step(2);
    RST = 1'b0;

    // Reset state
    check("rst_valid",    32'(bus.out_valid), 0);
    check("rst_err",      32'(bus.ERR),       0);
    check("rst_opa",      32'(bus.out_opa),   0);
    check("rst_opb",      32'(bus.out_opb),   0);
    check("rst_cmd",      32'(bus.out_cmd),   0);
    check("rst_in_ready", 32'(bus.in_ready),  1);

    // Both operands together, latency 1
    drive(2'b11, 8'h12, 8'h34, 4'd0);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    check_op("s1", 8'h12, 8'h34, 1'b0);
    step();
    check("s1_idle", 32'(bus.out_valid), 0);

    // Split arrival; first capture's CMD wins
    drive(2'b01, 8'hAA, 8'h00, 4'd3);
    step();
    check("s2_wait", 32'(bus.out_valid), 0);
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    step(5);
    check("s2_wait5", 32'(bus.out_valid), 0);
    drive(2'b10, 8'h00, 8'h55, 4'd7);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    check_op("s2", 8'hAA, 8'h55, 1'b0);
    check("s2_cmd", 32'(bus.out_cmd), 3);
    step();

    // Timeout
    run_timeout();

    // Completion on the last cycle of the window beats the timeout
    drive(2'b01, 8'h3C, 8'h00, 4'd9);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    step(15);
    check("edge_wait", 32'(bus.out_valid), 0);
    drive(2'b10, 8'h00, 8'hC3, 4'd1);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    check_op("edge", 8'h3C, 8'hC3, 1'b0);
    check("edge_cmd", 32'(bus.out_cmd), 9);
    step();

    // CE=0 freezes the timer
    drive(2'b01, 8'h21, 8'h00, 4'd4);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    bus.CE = 1'b0;
    step(20);
    check("s4_frozen", 32'(bus.out_valid), 0);
    bus.CE = 1'b1;
    drive(2'b10, 8'h00, 8'h43, 4'd0);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    check_op("s4", 8'h21, 8'h43, 1'b0);
    step();

    // Back-to-back stream with backpressure
    drive(2'b11, 8'h01, 8'h02, 4'd1);
    step();
    bus.out_ready = 1'b0;
    drive(2'b11, 8'h03, 8'h04, 4'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s5_in_ready_lo", 32'(bus.in_ready), 0);
      step();
      check_op("s5_hold", 8'h01, 8'h02, 1'b0);
      check("s5_hold_cmd", 32'(bus.out_cmd), 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("s5_in_ready_hi", 32'(bus.in_ready), 1);
    step();
    check_op("s5_op2", 8'h03, 8'h04, 1'b0);
    drive(2'b11, 8'h05, 8'h06, 4'd3);
    step();
    check_op("s5_op3", 8'h05, 8'h06, 1'b0);
    drive(2'b11, 8'h07, 8'h08, 4'd4);
    step();
    check_op("s5_op4", 8'h07, 8'h08, 1'b0);
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    step();
    check("s5_end", 32'(bus.out_valid), 0);

`ifdef ALU_PAIR_TIMEOUT_CNT_EN
    check("tcnt_one", 32'(timeout_count), 1);
    run_timeout();
    check("tcnt_two", 32'(timeout_count), 2);
`endif

    // Reset while waiting for OPB
    drive(2'b01, 8'h99, 8'h00, 4'd5);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("s6a_valid", 32'(bus.out_valid), 0);
    drive(2'b10, 8'h00, 8'h66, 4'd0);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    check("s6a_no_pair", 32'(bus.out_valid), 0);
    step(16);
    check_op("s6a_fresh_timeout", 8'h00, 8'h66, 1'b1);
    step();

    // Reset while holding an unaccepted operation
    drive(2'b11, 8'hDE, 8'hAD, 4'd6);
    step();
    drive(2'b00, 8'h00, 8'h00, 4'd0);
    check("s6b_hold", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("s6b_valid", 32'(bus.out_valid), 0);
    check("s6b_opa",   32'(bus.out_opa),   0);
    bus.out_ready = 1'b1;
    step(2);
    check("s6b_gone", 32'(bus.out_valid), 0);
`ifdef ALU_PAIR_TIMEOUT_CNT_EN
    check("tcnt_rst", 32'(timeout_count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
